// File: rtl/y86_regfile_sb.sv
// y86_regfile_sb: Y86-64 register file with two read ports, two write ports and a reservation scoreboard
// Ports: clk/rst_n (async active-low); srcA/srcB -> valA/valB comb reads;
//   dstE/valE, dstM/valM write ports (M wins on conflict);
//   rsvE/rsvM/rsv_valid reservations; stall read-hazard flag;
//   err_clr clears the sticky reg_error.
// Optional macro Y86_RF_BYPASS_EN: forward same-cycle write data to reads and relax stall.
module y86_regfile_sb #(
  parameter int DATA_W = 64,
  parameter int IDX_W = 4,
  parameter int NUM_REGS = 15,
  parameter int RNONE = 15,
  parameter int SP_IDX = 4,
  parameter logic [DATA_W-1:0] SP_RESET = 1023,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  srcA,
  input  logic [IDX_W-1:0]  srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [IDX_W-1:0]  dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [IDX_W-1:0]  dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [IDX_W-1:0]  rsvE,
  input  logic [IDX_W-1:0]  rsvM,
  input  logic              rsv_valid,
  output logic              stall,
  input  logic              err_clr,
  output logic              reg_error
);
  localparam int MAXC = (1 << PEND_W) - 1;
  function automatic logic vld(input logic [IDX_W-1:0] x);
    return int'(x) < NUM_REGS;
  endfunction
  function automatic logic ill(input logic [IDX_W-1:0] x);
    return !vld(x) && int'(x) != RNONE;
  endfunction
  logic [DATA_W-1:0] rd [NUM_REGS];
  logic [NUM_REGS-1:0] hz, ovf;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_r
    logic [DATA_W-1:0] q;
    logic [PEND_W-1:0] c;
    int inc, dec, nxt;
    assign inc = int'(rsv_valid && int'(rsvE) == i) + int'(rsv_valid && int'(rsvM) == i);
    assign dec = int'(int'(dstE) == i) + int'(int'(dstM) == i);
    // signed sum so that unreserved writes can go below zero before clamping
    assign nxt = int'(c) + inc - dec;
    assign ovf[i] = nxt > MAXC;
`ifdef Y86_RF_BYPASS_EN
    assign rd[i] = int'(dstM) == i ? valM : int'(dstE) == i ? valE : q;
    assign hz[i] = int'(c) - dec > 0;
`else
    assign rd[i] = q;
    assign hz[i] = c != '0 || dec != 0;
`endif
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        q <= i == SP_IDX ? SP_RESET : '0;
        c <= '0;
      end else begin
        if (int'(dstM) == i) q <= valM;
        else if (int'(dstE) == i) q <= valE;
        c <= PEND_W'(nxt < 0 ? 0 : nxt > MAXC ? MAXC : nxt);
      end
  end
  assign valA = vld(srcA) ? rd[srcA] : '0;
  assign valB = vld(srcB) ? rd[srcB] : '0;
  assign stall = (vld(srcA) && hz[srcA]) || (vld(srcB) && hz[srcB]);
  logic err_set;
  assign err_set = ill(srcA) || ill(srcB) || ill(dstE) || ill(dstM) ||
                   (rsv_valid && (ill(rsvE) || ill(rsvM))) || |ovf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) reg_error <= 1'b0;
    else reg_error <= err_set || (reg_error && !err_clr);
endmodule

// File: tb/tb_y86_regfile_sb.sv
// tb_y86_regfile_sb: table-driven scoreboard bench for y86_regfile_sb (main instance plus a NUM_REGS=14 instance for illegal indices)
module tb_y86_regfile_sb;
`ifdef Y86_RF_BYPASS_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  localparam int N = 15;
  logic clk = 0, rst_n = 0;
  logic [3:0] srcA, srcB, dstE, dstM, rsvE, rsvM;
  logic [63:0] valE, valM, valA, valB, valA2, valB2;
  logic rsv_valid, err_clr, stall, reg_error, stall2, reg_error2;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  y86_regfile_sb dut (.clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .rsvE(rsvE), .rsvM(rsvM),
    .rsv_valid(rsv_valid), .stall(stall), .err_clr(err_clr), .reg_error(reg_error));
  y86_regfile_sb #(.NUM_REGS(14)) u2 (.clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA2), .valB(valB2),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .rsvE(rsvE), .rsvM(rsvM),
    .rsv_valid(rsv_valid), .stall(stall2), .err_clr(err_clr), .reg_error(reg_error2));
  typedef struct {
    logic [3:0] sa, sb, de, dm, re, rm;
    logic [63:0] ve, vm, va, vb, va2;
    logic rv, ec, st, er, er2;
  } vec_t;
  typedef struct {
    string nm;
    logic [63:0] va, vb, va2;
    logic st, er, er2;
  } exp_t;
  vec_t vt[$];
  exp_t sb[$];
  function automatic vec_t mk(int sa, int sb, int de, int ve, int dm, int vm, int re, int rm, int rv, int ec,
                              int va, int vb, int va2, int st, int er, int er2);
    vec_t v;
    v.sa = 4'(sa); v.sb = 4'(sb); v.de = 4'(de); v.ve = 64'(ve); v.dm = 4'(dm); v.vm = 64'(vm);
    v.re = 4'(re); v.rm = 4'(rm); v.rv = rv != 0; v.ec = ec != 0;
    v.va = 64'(va); v.vb = 64'(vb); v.va2 = 64'(va2); v.st = st != 0; v.er = er != 0; v.er2 = er2 != 0;
    return v;
  endfunction
  function automatic vec_t idle(int sa, int sb, int ec, int va, int vb, int va2, int st, int er, int er2);
    return mk(sa, sb, N, 0, N, 0, N, N, 0, ec, va, vb, va2, st, er, er2);
  endfunction
  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic push(input string nm, input logic [63:0] va, input logic [63:0] vb, input logic [63:0] va2,
                      input logic st, input logic er, input logic er2);
    exp_t e;
    e.nm = nm; e.va = va; e.vb = vb; e.va2 = va2; e.st = st; e.er = er; e.er2 = er2;
    sb.push_back(e);
  endtask
  task automatic pop_check;
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    cmp({e.nm, ".valA"}, valA, e.va);
    cmp({e.nm, ".valB"}, valB, e.vb);
    cmp({e.nm, ".valA2"}, valA2, e.va2);
    cmp({e.nm, ".stall"}, 64'(stall), 64'(e.st));
    cmp({e.nm, ".reg_error"}, 64'(reg_error), 64'(e.er));
    cmp({e.nm, ".reg_error2"}, 64'(reg_error2), 64'(e.er2));
  endtask
  task automatic drive(input vec_t v);
    srcA = v.sa; srcB = v.sb; dstE = v.de; valE = v.ve; dstM = v.dm; valM = v.vm;
    rsvE = v.re; rsvM = v.rm; rsv_valid = v.rv; err_clr = v.ec;
  endtask
  task automatic set_idle(input int sa, input int sb);
    drive(idle(sa, sb, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    set_idle(4, 0);
    vt.push_back(idle(4, 0, 0, 1023, 0, 1023, 0, 0, 0));
    vt.push_back(mk(4, 1, 4, 'h10, 4, 'h20, N, N, 0, 0, B ? 'h20 : 1023, 0, B ? 'h20 : 1023, !B, 0, 0));
    vt.push_back(idle(4, 1, 0, 'h20, 0, 'h20, 0, 0, 0));
    vt.push_back(mk(3, 4, 3, 'hAB, N, 0, N, N, 0, 0, B ? 'hAB : 0, 'h20, B ? 'hAB : 0, !B, 0, 0));
    vt.push_back(idle(3, 4, 0, 'hAB, 'h20, 'hAB, 0, 0, 0));
    vt.push_back(mk(2, 3, N, 0, N, 0, 2, N, 1, 0, 0, 'hAB, 0, 0, 0, 0));
    vt.push_back(idle(2, 3, 0, 0, 'hAB, 0, 1, 0, 0));
    vt.push_back(idle(2, 3, 0, 0, 'hAB, 0, 1, 0, 0));
    vt.push_back(mk(2, 3, 2, 'h55, N, 0, N, N, 0, 0, B ? 'h55 : 0, 'hAB, B ? 'h55 : 0, !B, 0, 0));
    vt.push_back(idle(2, 3, 0, 'h55, 'hAB, 'h55, 0, 0, 0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 1, N, 0, N, 0, 5, N, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(idle(5, 0, 1, 0, 0, 0, 1, 1, 1));
    vt.push_back(idle(5, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(5, 0, 5, 1, 5, 2, N, N, 0, 0, B ? 2 : 0, 0, B ? 2 : 0, 1, 0, 0));
    vt.push_back(idle(5, 0, 0, 2, 0, 2, 1, 0, 0));
    vt.push_back(mk(5, 0, 5, 7, N, 0, N, N, 0, 0, B ? 7 : 2, 0, B ? 7 : 2, !B, 0, 0));
    vt.push_back(idle(5, 0, 0, 7, 0, 7, 0, 0, 0));
    vt.push_back(mk(6, 0, 6, 9, N, 0, 6, N, 1, 0, B ? 9 : 0, 0, B ? 9 : 0, !B, 0, 0));
    vt.push_back(idle(6, 0, 0, 9, 0, 9, 0, 0, 0));
    vt.push_back(mk(0, 0, N, 0, N, 0, N, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(idle(0, 7, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(0, 7, N, 0, 7, 'h77, N, N, 0, 0, 0, B ? 'h77 : 0, 0, !B, 0, 0));
    vt.push_back(idle(0, 7, 0, 0, 'h77, 0, 0, 0, 0));
    vt.push_back(idle(15, 15, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(idle(15, 15, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(14, 0, 14, 'hEE, N, 0, N, N, 0, 0, B ? 'hEE : 0, 0, 0, !B, 0, 0));
    vt.push_back(idle(14, 0, 0, 'hEE, 0, 0, 0, 0, 1));
    vt.push_back(idle(0, 14, 1, 0, 'hEE, 0, 0, 0, 1));
    vt.push_back(idle(0, 0, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      push($sformatf("vec%0d", i), vt[i].va, vt[i].vb, vt[i].va2, vt[i].st, vt[i].er, vt[i].er2);
      @(negedge clk) pop_check();
      @(posedge clk) #1;
    end
    // mid-operation async reset: build an overflow error on reg 0, then reset with traffic in flight
    drive(mk(4, 4, N, 0, N, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 set_idle(0, 4);
    push("pre_reset", 0, 'h20, 0, 1, 1, 1);
    @(negedge clk) pop_check();
    @(posedge clk) #1;
    drive(mk(8, 9, 9, 'h99, N, 0, 8, N, 1, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 0;
    #1 srcA = 4; srcB = 0;
    push("in_reset", 1023, 0, 1023, 0, 0, 0);
    #1 pop_check();
    @(posedge clk) #1;
    set_idle(0, 9);
    @(negedge clk) rst_n = 1;
    push("post_reset0", 0, 0, 0, 0, 0, 0);
    #1 pop_check();
    @(posedge clk) #1 set_idle(8, 4);
    push("post_reset1", 0, 1023, 0, 0, 0, 0);
    @(negedge clk) pop_check();
    if (sb.size() != 0) cmp("scoreboard_leftover", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
